vga_timing_rx: RTL and testbench

Receive-side VGA timing decoder: consumes HS/VS/BLANK_N as driven by the `vga` output block and reconstructs the raster. It runs on the board clock gated by a pixel strobe, and produces:
- active-pixel coordinates and a data-enable;
- measured line/frame totals and active width;
- a lock indication and a sticky error flag.

It closes the loop on the display path for self-check, so measured totals can be routed to `SevenHexDecoder` and LEDs. A capture/overlay path uses the coordinates.

---
 rtl/vga_timing_rx.sv | 186 ++++++++++++++++++
 tb/tb_vga_timing_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_rx.sv
// Receive-side VGA timing decoder: rebuilds the raster from HS/VS/BLANK_N,
// measures line/frame totals and active width, and tracks timing lock.
module vga_timing_rx #(
  parameter bit SYNC_POL    = 1'b0,
  parameter int CW          = 11,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_pix_en,
  input  logic          i_hs,
  input  logic          i_vs,
  input  logic          i_blank_n,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_de,
  output logic [CW-1:0] o_h_total,
  output logic [CW-1:0] o_v_total,
  output logic [CW-1:0] o_h_active,
  output logic          o_frame_pulse,
  output logic          o_locked,
  output logic          o_err
);

  localparam int RW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] MAXV = '1;

  typedef enum logic [1:0] {HUNT, MEASURE, LOCKED} state_t;

  logic          r_s_hs, r_p_hs, r_s_vs, r_p_vs, r_s_bl, r_p_bl;
  logic [CW-1:0] r_hcnt, r_vcnt, r_x, r_y;
  logic [CW-1:0] r_h_total, r_v_total, r_h_active;
  logic          r_vs_pend, r_h_bad, r_de, r_fp, r_err;
  state_t        r_state, w_state_nxt;
  logic [RW-1:0] r_run, w_run_nxt, w_run_inc;
  logic          w_loss;

  logic          w_hs_a, w_vs_a;
  logic          w_hs_lead, w_vs_lead, w_bl_rise, w_bl_fall, w_boundary;
  logic [CW-1:0] w_h_new, w_v_new;
  logic          w_h_chg, w_v_ok, w_sat, w_frame_ok;

  assign w_hs_a = SYNC_POL ? i_hs : ~i_hs;
  assign w_vs_a = SYNC_POL ? i_vs : ~i_vs;

  assign w_hs_lead  = r_s_hs & ~r_p_hs;
  assign w_vs_lead  = r_s_vs & ~r_p_vs;
  assign w_bl_rise  = r_s_bl & ~r_p_bl;
  assign w_bl_fall  = ~r_s_bl & r_p_bl;
  // A VS edge seen on the same sample as the HS edge closes the frame at once.
  assign w_boundary = w_hs_lead & (r_vs_pend | w_vs_lead);

  assign w_h_new    = r_hcnt + 1'b1;
  assign w_v_new    = r_vcnt + 1'b1;
  assign w_h_chg    = w_hs_lead & (w_h_new != r_h_total);
  assign w_v_ok     = (w_v_new == r_v_total);
  assign w_sat      = ~w_hs_lead & (r_hcnt == MAXV);
  assign w_frame_ok = ~r_h_bad & ~w_h_chg & w_v_ok;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s_hs <= 1'b0; r_p_hs <= 1'b0;
      r_s_vs <= 1'b0; r_p_vs <= 1'b0;
      r_s_bl <= 1'b0; r_p_bl <= 1'b0;
    end else if (i_pix_en) begin
      r_s_hs <= w_hs_a;    r_p_hs <= r_s_hs;
      r_s_vs <= w_vs_a;    r_p_vs <= r_s_vs;
      r_s_bl <= i_blank_n; r_p_bl <= r_s_bl;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_h_total  <= '0;
      r_v_total  <= '0;
      r_vs_pend  <= 1'b0;
      r_h_bad    <= 1'b0;
      r_fp       <= 1'b0;
    end else begin
      r_fp <= 1'b0;
      if (i_pix_en) begin
        r_fp <= w_boundary;
        if (w_hs_lead) begin
          r_hcnt    <= '0;
          r_h_total <= w_h_new;
        end else if (r_hcnt != MAXV) begin
          r_hcnt <= w_h_new;
        end
        // r_h_bad remembers any line-length change inside the current frame.
        if (w_boundary) begin
          r_v_total <= w_v_new;
          r_vcnt    <= '0;
          r_vs_pend <= 1'b0;
          r_h_bad   <= 1'b0;
        end else begin
          if (w_hs_lead && r_vcnt != MAXV) r_vcnt <= w_v_new;
          if (w_vs_lead) r_vs_pend <= 1'b1;
          if (w_h_chg) r_h_bad <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_x        <= '0;
      r_y        <= '0;
      r_de       <= 1'b0;
      r_h_active <= '0;
    end else if (i_pix_en) begin
      r_de <= r_s_bl;
      if (w_bl_rise) r_x <= '0;
      else if (r_s_bl && r_x != MAXV) r_x <= r_x + 1'b1;
      if (w_bl_fall) r_h_active <= r_x + 1'b1;
      if (w_boundary) r_y <= '0;
      else if (w_bl_fall && r_y != MAXV) r_y <= r_y + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= HUNT;
      r_run   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      r_err   <= r_err | w_loss;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_run_inc   = r_run + 1'b1;
    w_loss      = 1'b0;
    if (i_pix_en) begin
      case (r_state)
        HUNT: begin
          // The frame in progress at reset is partial; start measuring after it.
          if (w_boundary) begin
            w_state_nxt = MEASURE;
            w_run_nxt   = '0;
          end
        end
        MEASURE: begin
          if (w_sat) begin
            w_state_nxt = HUNT;
            w_run_nxt   = '0;
          end else if (w_boundary) begin
            w_run_nxt = (r_run == '0 || w_frame_ok) ? w_run_inc : RW'(1);
            if (w_run_nxt >= RW'(LOCK_FRAMES)) w_state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (w_sat) begin
            w_state_nxt = HUNT;
            w_run_nxt   = '0;
            w_loss      = 1'b1;
          end else if (w_h_chg || (w_boundary && !w_v_ok)) begin
            w_state_nxt = MEASURE;
            w_run_nxt   = '0;
            w_loss      = 1'b1;
          end
        end
        default: begin
          w_state_nxt = HUNT;
          w_run_nxt   = '0;
        end
      endcase
    end
  end

  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_de          = r_de;
  assign o_h_total     = r_h_total;
  assign o_v_total     = r_v_total;
  assign o_h_active    = r_h_active;
  assign o_frame_pulse = r_fp;
  assign o_locked      = (r_state == LOCKED);
  assign o_err         = r_err;

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx: two instances (active-low and active-high sync) fed one
// randomised raster, checked against expectations derived from the video mode.
module tb_vga_timing_rx;
  localparam int CW = 11;
  localparam int LOCK_FRAMES = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, pix_en, hs, vs, bl;
  logic hs0, vs0, hs1, vs1;
  assign hs0 = ~hs;
  assign vs0 = ~vs;
  assign hs1 = hs;
  assign vs1 = vs;

  logic [1:0][CW-1:0] ox, oy, oht, ovt, oha;
  logic [1:0]         ode, ofp, olk, oerr;

  vga_timing_rx #(.SYNC_POL(1'b0), .CW(CW), .LOCK_FRAMES(LOCK_FRAMES)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_hs(hs0), .i_vs(vs0),
    .i_blank_n(bl), .o_x(ox[0]), .o_y(oy[0]), .o_de(ode[0]), .o_h_total(oht[0]),
    .o_v_total(ovt[0]), .o_h_active(oha[0]), .o_frame_pulse(ofp[0]),
    .o_locked(olk[0]), .o_err(oerr[0]));

  vga_timing_rx #(.SYNC_POL(1'b1), .CW(CW), .LOCK_FRAMES(LOCK_FRAMES)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_hs(hs1), .i_vs(vs1),
    .i_blank_n(bl), .o_x(ox[1]), .o_y(oy[1]), .o_de(ode[1]), .o_h_total(oht[1]),
    .o_v_total(ovt[1]), .o_h_active(oha[1]), .o_frame_pulse(ofp[1]),
    .o_locked(olk[1]), .o_err(oerr[1]));

  int n_pass = 0;
  int n_total = 0;

  // video mode (logical, active-high sync)
  int htot, hact, hs_st, hsw, vtot, vact, vs_st, vsw, vs_col;
  int gap_lo, gap_hi;

  // event monitor: frame pulses, pulse width, lock rise/fall
  int fp_cnt[2] = '{0, 0};
  int fp_wide[2] = '{0, 0};
  int lock_rise_fp[2] = '{-100, -100};
  int unlock_cnt[2] = '{0, 0};
  logic [CW-1:0] unlock_h[2];
  logic [1:0] prev_fp = '0, prev_lk = '0;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ofp[d]) fp_cnt[d] <= fp_cnt[d] + 1;
      if (ofp[d] && prev_fp[d]) fp_wide[d] <= fp_wide[d] + 1;
      if (olk[d] && !prev_lk[d]) lock_rise_fp[d] <= fp_cnt[d] + (ofp[d] ? 1 : 0);
      if (!olk[d] && prev_lk[d]) begin
        unlock_cnt[d] <= unlock_cnt[d] + 1;
        unlock_h[d]   <= oht[d];
      end
    end
    prev_fp <= ofp;
    prev_lk <= olk;
  end

  task automatic new_mode();
    int hfp, hbp, vfp, vbp;
    hact = $urandom_range(16, 32); hfp = $urandom_range(1, 4);
    hsw  = $urandom_range(2, 6);   hbp = $urandom_range(1, 4);
    htot = hact + hfp + hsw + hbp; hs_st = hact + hfp;
    vact = $urandom_range(8, 16);  vfp = $urandom_range(1, 3);
    vsw  = $urandom_range(1, 3);   vbp = $urandom_range(1, 3);
    vtot = vact + vfp + vsw + vbp; vs_st = vact + vfp;
    vs_col = ($urandom_range(0, 1) == 1) ? hs_st : 0;
  endtask

  function automatic void pixel_at(input int l, input int c,
                                   output logic h, output logic v, output logic b);
    int idx;
    idx = l * htot + c;
    b = (l < vact) && (c < hact);
    h = (c >= hs_st) && (c < hs_st + hsw);
    v = (idx >= vs_st * htot + vs_col) && (idx < (vs_st + vsw) * htot + vs_col);
  endfunction

  // one pixel strobe, then idle clocks carrying junk that must be ignored
  task automatic pix(input logic h, input logic v, input logic b);
    hs = h; vs = v; bl = b; pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    repeat ($urandom_range(gap_lo, gap_hi)) begin
      hs = 1'($urandom); vs = 1'($urandom); bl = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_frame(input int short_line);
    logic h, v, b;
    for (int l = 0; l < vtot; l++)
      for (int c = 0; c < ((l == short_line) ? htot - 1 : htot); c++) begin
        pixel_at(l, c, h, v, b);
        pix(h, v, b);
      end
  endtask

  task automatic test_reset(input bit mid);
    logic h, v, b;
    if (mid) begin
      for (int l = 0; l <= vact / 2; l++)
        for (int c = 0; c < ((l == vact / 2) ? hact / 2 : htot); c++) begin
          pixel_at(l, c, h, v, b);
          pix(h, v, b);
        end
      pixel_at(vact / 2, hact / 2, h, v, b);
      hs = h; vs = v; bl = b; pix_en = 1'b1; rst_n = 1'b0;
      @(posedge clk); #1;
    end else begin
      rst_n = 1'b0;
      repeat (4) begin
        hs = 1'($urandom); vs = 1'($urandom); bl = 1'($urandom); pix_en = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    rst_n = 1'b1; pix_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_total++; if (ox[d]  !== '0) $display("FAIL rst_x dut%0d mid%0d got %0d want 0", d, mid, ox[d]); else n_pass++;
      n_total++; if (oy[d]  !== '0) $display("FAIL rst_y dut%0d mid%0d got %0d want 0", d, mid, oy[d]); else n_pass++;
      n_total++; if (ode[d] !== 1'b0) $display("FAIL rst_de dut%0d mid%0d got %0b want 0", d, mid, ode[d]); else n_pass++;
      n_total++; if (oht[d] !== '0) $display("FAIL rst_h_total dut%0d mid%0d got %0d want 0", d, mid, oht[d]); else n_pass++;
      n_total++; if (ovt[d] !== '0) $display("FAIL rst_v_total dut%0d mid%0d got %0d want 0", d, mid, ovt[d]); else n_pass++;
      n_total++; if (oha[d] !== '0) $display("FAIL rst_h_active dut%0d mid%0d got %0d want 0", d, mid, oha[d]); else n_pass++;
      n_total++; if (ofp[d] !== 1'b0) $display("FAIL rst_frame_pulse dut%0d mid%0d got %0b want 0", d, mid, ofp[d]); else n_pass++;
      n_total++; if (olk[d] !== 1'b0) $display("FAIL rst_locked dut%0d mid%0d got %0b want 0", d, mid, olk[d]); else n_pass++;
      n_total++; if (oerr[d] !== 1'b0) $display("FAIL rst_err dut%0d mid%0d got %0b want 0", d, mid, oerr[d]); else n_pass++;
    end
  endtask

  // fresh mode from a HUNT state: partial first frame, then LOCK_FRAMES frames to lock
  task automatic test_clean_lock(input bit exp_err);
    int f0[2], w0[2];
    new_mode();
    for (int d = 0; d < 2; d++) begin f0[d] = fp_cnt[d]; w0[d] = fp_wide[d]; end
    repeat (4) drive_frame(-1);
    for (int d = 0; d < 2; d++) begin
      n_total++; if (oht[d] !== CW'(htot)) $display("FAIL lock_h_total dut%0d got %0d want %0d", d, oht[d], htot); else n_pass++;
      n_total++; if (ovt[d] !== CW'(vtot)) $display("FAIL lock_v_total dut%0d got %0d want %0d", d, ovt[d], vtot); else n_pass++;
      n_total++; if (oha[d] !== CW'(hact)) $display("FAIL lock_h_active dut%0d got %0d want %0d", d, oha[d], hact); else n_pass++;
      n_total++; if (fp_cnt[d] - f0[d] !== 4) $display("FAIL lock_pulses dut%0d got %0d want 4", d, fp_cnt[d] - f0[d]); else n_pass++;
      n_total++; if (fp_wide[d] - w0[d] !== 0) $display("FAIL lock_pulse_width dut%0d wide=%0d want 0", d, fp_wide[d] - w0[d]); else n_pass++;
      n_total++; if (lock_rise_fp[d] - f0[d] !== 1 + LOCK_FRAMES) $display("FAIL lock_boundary dut%0d got %0d want %0d", d, lock_rise_fp[d] - f0[d], 1 + LOCK_FRAMES); else n_pass++;
      n_total++; if (olk[d] !== 1'b1) $display("FAIL lock_locked dut%0d got %0b want 1", d, olk[d]); else n_pass++;
      n_total++; if (oerr[d] !== exp_err) $display("FAIL lock_err dut%0d got %0b want %0b", d, oerr[d], exp_err); else n_pass++;
    end
  endtask

  // per-pixel coordinates: outputs after strobe k describe pixel k-1
  task automatic test_sweep();
    logic h, v, b, pb;
    int pl, pc;
    pl = -1; pc = 0; pb = 1'b0;
    for (int l = 0; l < vtot; l++)
      for (int c = 0; c < htot; c++) begin
        pixel_at(l, c, h, v, b);
        pix(h, v, b);
        if (pl >= 0) begin
          for (int d = 0; d < 2; d++) begin
            n_total++; if (ode[d] !== pb) $display("FAIL sweep_de dut%0d at %0d,%0d got %0b want %0b", d, pc, pl, ode[d], pb); else n_pass++;
            if (pb) begin
              n_total++;
              if (ox[d] !== CW'(pc) || oy[d] !== CW'(pl))
                $display("FAIL sweep_xy dut%0d got %0d,%0d want %0d,%0d", d, ox[d], oy[d], pc, pl);
              else n_pass++;
            end
          end
        end
        pl = l; pc = c; pb = b;
      end
  endtask

  task automatic test_glitch();
    int u0[2], g;
    g = $urandom_range(1, vact - 2);
    for (int d = 0; d < 2; d++) u0[d] = unlock_cnt[d];
    drive_frame(g);
    for (int d = 0; d < 2; d++) begin
      n_total++; if (unlock_cnt[d] - u0[d] !== 1) $display("FAIL glitch_unlocks dut%0d got %0d want 1", d, unlock_cnt[d] - u0[d]); else n_pass++;
      n_total++; if (unlock_h[d] !== CW'(htot - 1)) $display("FAIL glitch_drop_h dut%0d got %0d want %0d", d, unlock_h[d], htot - 1); else n_pass++;
      n_total++; if (olk[d] !== 1'b0) $display("FAIL glitch_locked dut%0d got %0b want 0", d, olk[d]); else n_pass++;
      n_total++; if (oerr[d] !== 1'b1) $display("FAIL glitch_err dut%0d got %0b want 1", d, oerr[d]); else n_pass++;
    end
    repeat (2) drive_frame(-1);
    for (int d = 0; d < 2; d++) begin
      n_total++; if (olk[d] !== 1'b1) $display("FAIL relock_locked dut%0d got %0b want 1", d, olk[d]); else n_pass++;
      n_total++; if (oerr[d] !== 1'b1) $display("FAIL relock_err dut%0d got %0b want 1", d, oerr[d]); else n_pass++;
    end
  endtask

  task automatic test_sync_loss();
    int u0[2];
    for (int d = 0; d < 2; d++) u0[d] = unlock_cnt[d];
    gap_lo = 0; gap_hi = 0;
    repeat (2100 + htot) pix(1'b0, 1'b0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      n_total++; if (unlock_cnt[d] - u0[d] !== 1) $display("FAIL sat_unlocks dut%0d got %0d want 1", d, unlock_cnt[d] - u0[d]); else n_pass++;
      n_total++; if (olk[d] !== 1'b0) $display("FAIL sat_locked dut%0d got %0b want 0", d, olk[d]); else n_pass++;
      n_total++; if (oerr[d] !== 1'b1) $display("FAIL sat_err dut%0d got %0b want 1", d, oerr[d]); else n_pass++;
    end
    gap_lo = 0; gap_hi = 2;
    test_clean_lock(1'b1);
  endtask

  initial begin
    rst_n = 1'b0; pix_en = 1'b0; hs = 1'b0; vs = 1'b0; bl = 1'b0;
    gap_lo = 1; gap_hi = 1;
    new_mode();
    test_reset(1'b0);
    test_clean_lock(1'b0);
    gap_lo = 0; gap_hi = 2;
    test_sweep();
    test_glitch();
    test_sync_loss();
    test_reset(1'b1);
    test_clean_lock(1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
